// File: rtl/telemetry_pkg.sv
// Shared types and helpers for the UART telemetry framer: FSM states,
// frame phases, line-ending characters and nibble-to-ASCII conversion.
package telemetry_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACK,
    WAIT_IDLE,
    ADV
  } state_t;

  typedef enum logic [2:0] {
    HDR,
    DIG,
    SEP,
    CR,
    LF
  } phase_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Uppercase hex: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h0, nib} + 8'h30;
    else             return {4'h0, nib} + 8'h37;
  endfunction

endpackage

// File: rtl/period_tick_gen.sv
// Free-running period counter producing a one-cycle tick every PERIOD_CYCLES
// clocks while enabled; counter is held at zero when disabled.
module period_tick_gen #(
  parameter int PERIOD_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)             count <= '0;
    else if (!en)           count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/uart_telemetry_framer.sv
// Snapshots channel words on a trigger and streams them as one ASCII hex line
// ("$" hex [sep hex]... CR LF) to a start/busy UART transmitter.
module uart_telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int         NUM_CH        = 4,
  parameter int         CH_WIDTH      = 16,
  parameter int         PERIOD_CYCLES = 10000,
  parameter logic [7:0] HEADER_CHAR   = 8'h24,
  parameter logic [7:0] SEP_CHAR      = 8'h20,
  parameter int         ACK_TIMEOUT   = 8
) (
  input  logic                       CLK_10MHZ,
  input  logic                       rst_n,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic                       periodic_en,
  input  logic                       sw_trig,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic                       frame_busy,
  output logic                       frame_done,
  output logic [7:0]                 overrun_cnt,
  output logic                       tx_err,
  output state_t                     fsm_state
);

  localparam int ND  = CH_WIDTH / 4;
  localparam int DW  = (ND > 1) ? $clog2(ND) : 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(ND - 1);

  state_t                     state, nxt_state;
  phase_t                     phase_q, nxt_phase;
  logic [CHW-1:0]             ch_q, nxt_ch, first_ch, after_ch;
  logic [DW-1:0]              dig_q, nxt_dig;
  logic                       has_first, has_after;
  logic [NUM_CH*CH_WIDTH-1:0] snap_data;
  logic [NUM_CH-1:0]          snap_en;
  logic [TW-1:0]              tmo_q;
  logic [7:0]                 nxt_char;
  logic [3:0]                 nib;
  int                         shamt;
  logic                       tick, trig;

  period_tick_gen #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
    .clk   (CLK_10MHZ),
    .rst_n (rst_n),
    .en    (periodic_en),
    .tick  (tick)
  );

  assign trig = tick | sw_trig;

  // Handshake: tx_start is a one-cycle strobe issued only while tx_busy=0; the
  // character is accepted once tx_busy rises, and tx_data is held until the
  // pointer advances after tx_busy falls again.
  assign tx_start   = (state == SEND) && !tx_busy;
  assign frame_busy = (state != IDLE);
  assign frame_done = (state == ADV) && (phase_q == LF);
  assign fsm_state  = state;

  always_ff @(posedge CLK_10MHZ) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:      if (trig) nxt_state = LOAD;
      LOAD:      nxt_state = SEND;
      SEND:      if (!tx_busy) nxt_state = WAIT_ACK;
      WAIT_ACK:  if (tx_busy) nxt_state = WAIT_IDLE;
                 else if (tmo_q == TMO_LAST) nxt_state = ADV;
      WAIT_IDLE: if (!tx_busy) nxt_state = ADV;
      ADV:       nxt_state = (phase_q == LF) ? IDLE : SEND;
      default:   nxt_state = IDLE;
    endcase
  end

  // Lowest enabled channel overall, and lowest enabled channel above ch_q.
  always_comb begin
    first_ch  = '0;
    has_first = 1'b0;
    after_ch  = '0;
    has_after = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (snap_en[i]) begin
        first_ch  = CHW'(i);
        has_first = 1'b1;
        if (i > int'(ch_q)) begin
          after_ch  = CHW'(i);
          has_after = 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt_phase = phase_q;
    nxt_ch    = ch_q;
    nxt_dig   = dig_q;
    unique case (phase_q)
      HDR: begin
        if (has_first) begin
          nxt_phase = DIG;
          nxt_ch    = first_ch;
          nxt_dig   = '0;
        end else begin
          nxt_phase = CR;
        end
      end
      DIG: begin
        if (dig_q != DIG_LAST) nxt_dig = dig_q + DW'(1);
        else if (has_after)    nxt_phase = SEP;
        else                   nxt_phase = CR;
      end
      SEP: begin
        nxt_phase = DIG;
        nxt_ch    = after_ch;
        nxt_dig   = '0;
      end
      CR:      nxt_phase = LF;
      default: nxt_phase = LF;
    endcase

    // Digit 0 is the most significant nibble of the channel word.
    shamt = int'(nxt_ch) * CH_WIDTH + (ND - 1 - int'(nxt_dig)) * 4;
    nib   = 4'(snap_data >> shamt);
    unique case (nxt_phase)
      HDR:     nxt_char = HEADER_CHAR;
      DIG:     nxt_char = hex_ascii(nib);
      SEP:     nxt_char = SEP_CHAR;
      CR:      nxt_char = CHAR_CR;
      default: nxt_char = CHAR_LF;
    endcase
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (!rst_n) begin
      snap_data   <= '0;
      snap_en     <= '0;
      phase_q     <= HDR;
      ch_q        <= '0;
      dig_q       <= '0;
      tx_data     <= '0;
      tmo_q       <= '0;
      overrun_cnt <= '0;
      tx_err      <= 1'b0;
    end else begin
      if (trig && (state != IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
      unique case (state)
        LOAD: begin
          snap_data <= ch_data;
          snap_en   <= ch_enable;
          phase_q   <= HDR;
          ch_q      <= '0;
          dig_q     <= '0;
          tx_data   <= HEADER_CHAR;
        end
        SEND: tmo_q <= '0;
        WAIT_ACK: begin
          if (!tx_busy) begin
            tmo_q <= tmo_q + TW'(1);
            if (tmo_q == TMO_LAST) tx_err <= 1'b1;
          end
        end
        ADV: begin
          phase_q <= nxt_phase;
          ch_q    <= nxt_ch;
          dig_q   <= nxt_dig;
          tx_data <= nxt_char;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_telemetry_framer.sv
// Directed bench for uart_telemetry_framer with a start/busy transmitter model
// and hand-written expected lines.
module tb_uart_telemetry_framer;
  import telemetry_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ch_data = '0;
  logic [1:0]  ch_enable = '0;
  logic        periodic_en = 1'b0;
  logic        sw_trig = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic        frame_done;
  logic [7:0]  overrun_cnt;
  logic        tx_err;
  state_t      fsm_state;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic busy_en = 1'b1;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int hdr_q[$];

  uart_telemetry_framer #(
    .NUM_CH(2), .CH_WIDTH(16), .PERIOD_CYCLES(100),
    .HEADER_CHAR(8'h24), .SEP_CHAR(8'h20), .ACK_TIMEOUT(8)
  ) dut (
    .CLK_10MHZ(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_enable(ch_enable),
    .periodic_en(periodic_en), .sw_trig(sw_trig), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .frame_busy(frame_busy),
    .frame_done(frame_done), .overrun_cnt(overrun_cnt), .tx_err(tx_err),
    .fsm_state(fsm_state)
  );

  // Clock / reset-related bookkeeping
  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises one cycle after tx_start and stays high 20 cycles.
  int  busy_left = 0;
  logic arm = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_busy   = 1'b0;
      arm       = 1'b0;
      busy_left = 0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (arm) begin
        tx_busy   = 1'b1;
        busy_left = 20;
        arm       = 1'b0;
      end
      if (tx_start) begin
        got_q.push_back(tx_data);
        if (tx_data == 8'h24) hdr_q.push_back(cyc);
        if (busy_en) arm = 1'b1;
      end
    end
  end

  always @(negedge clk) if (frame_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic pulse_trig();
    @(negedge clk) sw_trig = 1'b1;
    @(negedge clk) sw_trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (frame_busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard: expected line is body + CR LF
  task automatic check_frame(input string tag, input string body);
    exp_q.delete();
    for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_chr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_frame(input string tag, input string body,
                           input logic [31:0] data, input logic [1:0] en);
    int d0;
    ch_data = data;
    ch_enable = en;
    got_q.delete();
    d0 = done_cnt;
    pulse_trig();
    wait_idle(tag, 1500);
    check_frame(tag, body);
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, n, h;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_frame_busy", 32'(frame_busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    check("rst_tx_err", 32'(tx_err), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame with latency check
    ch_data = {16'h00F0, 16'h12AB};
    ch_enable = 2'b11;
    got_q.delete();
    d0 = done_cnt;
    pulse_trig();
    check("lat_load", 32'(tx_start), 32'd0);
    check("lat_busy", 32'(frame_busy), 32'd1);
    @(negedge clk);
    check("lat_start", 32'(tx_start), 32'd1);
    check("lat_hdr", 32'(tx_data), 32'h24);
    wait_idle("basic", 1500);
    check_frame("basic", "$12AB 00F0");
    check("basic_done", 32'(done_cnt - d0), 32'd1);

    // Masks
    run_frame("mask10", "$00F0", {16'h00F0, 16'h12AB}, 2'b10);
    run_frame("mask01", "$12AB", {16'h00F0, 16'h12AB}, 2'b01);
    run_frame("mask00", "$", {16'h00F0, 16'h12AB}, 2'b00);
    run_frame("digits", "$9A0F 7C3E", {16'h7C3E, 16'h9A0F}, 2'b11);

    // Overrun: three extra triggers during one frame
    ch_data = {16'h00F0, 16'h12AB};
    ch_enable = 2'b11;
    got_q.delete();
    d0 = done_cnt;
    pulse_trig();
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_trig();
      repeat (4) @(negedge clk);
    end
    wait_idle("ovr3", 1500);
    check("ovr3_cnt", 32'(overrun_cnt), 32'd3);
    check("ovr3_done", 32'(done_cnt - d0), 32'd1);
    check_frame("ovr3", "$12AB 00F0");

    // Overrun saturation
    @(negedge clk) sw_trig = 1'b1;
    repeat (300) @(negedge clk);
    sw_trig = 1'b0;
    check("ovr_sat", 32'(overrun_cnt), 32'd255);
    wait_idle("ovr_sat", 1500);
    check("ovr_sat_hold", 32'(overrun_cnt), 32'd255);

    // Snapshot: inputs change after LOAD
    ch_data = {16'hBEEF, 16'h0123};
    ch_enable = 2'b11;
    got_q.delete();
    pulse_trig();
    repeat (3) @(negedge clk);
    ch_data = 32'hFFFF_FFFF;
    ch_enable = 2'b00;
    wait_idle("snap", 1500);
    check_frame("snap", "$0123 BEEF");

    // Acknowledge timeout: transmitter never raises busy
    busy_en = 1'b0;
    ch_enable = 2'b00;
    got_q.delete();
    d0 = done_cnt;
    check("tmo_err_pre", 32'(tx_err), 32'd0);
    pulse_trig();
    @(negedge clk);
    check("tmo_start", 32'(tx_start), 32'd1);
    repeat (8) @(negedge clk);
    check("tmo_err_early", 32'(tx_err), 32'd0);
    @(negedge clk);
    check("tmo_err_set", 32'(tx_err), 32'd1);
    wait_idle("tmo", 500);
    check_frame("tmo", "$");
    check("tmo_done", 32'(done_cnt - d0), 32'd1);
    check("tmo_err_sticky", 32'(tx_err), 32'd1);
    busy_en = 1'b1;

    // Reset mid-frame after the fifth character
    ch_data = {16'h00F0, 16'h12AB};
    ch_enable = 2'b11;
    got_q.delete();
    pulse_trig();
    n = 0;
    while (got_q.size() < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_five", 32'(got_q.size()), 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_tx_start", 32'(tx_start), 32'd0);
    check("mid_tx_data", 32'(tx_data), 32'd0);
    check("mid_frame_busy", 32'(frame_busy), 32'd0);
    check("mid_frame_done", 32'(frame_done), 32'd0);
    check("mid_overrun", 32'(overrun_cnt), 32'd0);
    check("mid_tx_err", 32'(tx_err), 32'd0);
    check("mid_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("post_rst", "$12AB 00F0", {16'h00F0, 16'h12AB}, 2'b11);

    // Periodic triggering, then a sw_trig coinciding with a tick
    ch_enable = 2'b00;
    hdr_q.delete();
    @(negedge clk) periodic_en = 1'b1;
    n = 0;
    while (hdr_q.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("per_two", 32'(hdr_q.size() >= 2), 32'd1);
    if (hdr_q.size() >= 2) begin
      check("per_gap1", 32'(hdr_q[1] - hdr_q[0]), 32'd100);
      h = hdr_q[1];
      n = 0;
      while (cyc != h + 98 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("per_align", 32'(cyc), 32'(h + 98));
      sw_trig = 1'b1;
      @(negedge clk) sw_trig = 1'b0;
      n = 0;
      while (hdr_q.size() < 4 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("per_four", 32'(hdr_q.size() >= 4), 32'd1);
      if (hdr_q.size() >= 4) begin
        check("per_gap2", 32'(hdr_q[2] - hdr_q[1]), 32'd100);
        check("per_gap3", 32'(hdr_q[3] - hdr_q[2]), 32'd100);
      end
      check("per_no_ovr", 32'(overrun_cnt), 32'd0);
    end
    periodic_en = 1'b0;
    wait_idle("per_end", 500);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_telemetry_framer.md
Name: uart_telemetry_framer

Overview:
Parametrised successor to the hand-coded periodic UART status line in the top level. It snapshots NUM_CH channel words on a trigger. Each enabled channel is rendered as uppercase ASCII hex with separators, a header character and CR/LF. Characters go one at a time to the existing async_transmitter through its start/busy handshake. It sits between the sensor/controller blocks (ADC SPI, 1-wire temperature, bill validator) and the TX transmitter.

Parameters:
NUM_CH, 4, number of channel inputs (1..8)
CH_WIDTH, 16, bits per channel; multiple of 4; hex digits per channel ND = CH_WIDTH/4
PERIOD_CYCLES, 10000, clock cycles between periodic triggers (>= 2)
HEADER_CHAR, 8'h24 ("$"), first character of every frame
SEP_CHAR, 8'h20 (" "), separator between enabled channels
ACK_TIMEOUT, 8, cycles to wait for tx_busy to rise after tx_start

Ports:
CLK_10MHZ  in  1  system clock
rst_n  in  1  synchronous active-low reset
ch_data  in  NUM_CH*CH_WIDTH  channel words; channel i at [i*CH_WIDTH +: CH_WIDTH]
ch_enable  in  NUM_CH  per-channel inclusion mask, sampled at snapshot
periodic_en  in  1  enables the internal period counter
sw_trig  in  1  one-cycle software frame request
tx_busy  in  1  transmitter busy (TxD_busy)
tx_start  out  1  one-cycle send strobe (TxD_start)
tx_data  out  8  character to send (TxD_data), stable from tx_start until tx_busy falls
frame_busy  out  1  high from snapshot until frame_done
frame_done  out  1  one-cycle pulse after LF is accepted and tx_busy falls
overrun_cnt  out  8  dropped triggers, saturating
tx_err  out  1  sticky: tx_busy did not rise within ACK_TIMEOUT

Behaviour:
- Reset (rst_n=0 at a clock edge): tx_start=0, tx_data=0, frame_busy=0, frame_done=0, overrun_cnt=0, tx_err=0, period counter=0, FSM=IDLE. Reset mid-frame abandons the frame immediately; the partial line is not completed.
- Period counter: counts 0..PERIOD_CYCLES-1 while periodic_en=1 and wraps. tick=1 on the count==PERIOD_CYCLES-1 cycle. Held at 0 while periodic_en=0.
- trig = tick | sw_trig.
  - trig in IDLE starts a frame.
  - trig in any other state: overrun_cnt += 1, saturating at 255. The frame in progress is unaffected.
  - tick and sw_trig in the same cycle count as one trigger.
- Frame content, in order:
  - HEADER_CHAR.
  - For each enabled channel in ascending index: ND hex digits, MSB nibble first.
  - SEP_CHAR between consecutive enabled channels only; no leading or trailing separator.
  - 8'h0D, 8'h0A.
  - With ch_enable=0 the frame is HEADER, CR, LF.
- Hex encoding: nibble<10 -> nibble+8'h30; else nibble+8'h37 (A-F).
- FSM:
  - IDLE: on trig -> LOAD.
  - LOAD (1 cycle): latch ch_data and ch_enable into the snapshot; frame_busy=1; set char pointer to HEADER -> SEND.
  - SEND: when tx_busy=0, drive tx_data and pulse tx_start for 1 cycle -> WAIT_ACK. Otherwise hold in SEND.
  - WAIT_ACK: on tx_busy=1 -> WAIT_IDLE. After ACK_TIMEOUT cycles without tx_busy, set tx_err=1 -> ADV.
  - WAIT_IDLE: on tx_busy=0 -> ADV.
  - ADV: if the current char is LF, pulse frame_done, clear frame_busy -> IDLE. Otherwise step the pointer -> SEND.
- Pointer sequencing (phase, channel, digit):
  - Skip disabled channels.
  - After the last digit of a channel, go to SEP if another enabled channel follows, else CR.
- Latency: trig at cycle t -> LOAD at t+1 -> first tx_start at t+2 if tx_busy=0.
- Input changes after LOAD do not affect the current frame.

Decomposition:
- Package telemetry_pkg:
  - FSM state enum (IDLE, LOAD, SEND, WAIT_ACK, WAIT_IDLE, ADV).
  - Phase enum (HDR, DIG, SEP, CR, LF).
  - CR/LF constants.
  - Hex-to-ASCII function.
- Sub-module period_tick_gen: the period counter and tick output, reusable for the 1-wire start strobe.

Test Plan:
- Bench setup: NUM_CH=2, CH_WIDTH=16. Transmitter BFM raises busy 1 cycle after tx_start and holds it 20 cycles.
- Basic frame: ch_data={16'h00F0,16'h12AB}, ch_enable=2'b11, sw_trig pulse -> bytes "$12AB 00F0\r\n" (12 chars), then one frame_done; first tx_start exactly 2 cycles after sw_trig.
- Mask: ch_enable=2'b10 -> "$00F0\r\n"; ch_enable=2'b00 -> "$\r\n"; no separators emitted.
- Overrun: 3 extra sw_trig pulses during a frame -> overrun_cnt=3; exactly one frame sent. 300 extra triggers -> overrun_cnt stays 255.
- Periodic: PERIOD_CYCLES=100, periodic_en=1, ch_enable=0 -> frames start every 100 cycles. Simultaneous tick and sw_trig counts as one frame, no overrun.
- Snapshot/timeout: change ch_data mid-frame -> output unchanged. BFM never asserts busy -> tx_err=1 after 8 cycles and the frame still completes with frame_done.
- Reset mid-frame: rst_n=0 after the 5th char -> all outputs 0 next cycle. A new sw_trig then produces a complete frame starting with "$".
